// File: rtl/fma_pkg.sv
// Shared definitions for the dot-product sequencer and its paired FMA unit.
//   seq_state_t      : sequencer FSM states
//   FMA_WIDTH        : default fixed-point operand width
//   FMA_FIXED_POINT  : default number of fractional bits (Q6.10 by default)
package fma_pkg;

  localparam int FMA_WIDTH       = 16;
  localparam int FMA_FIXED_POINT = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    ZERO  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/fma.sv
// Fixed-point fused multiply-add with a registered accumulator output.
// On compute: out <= ((a * b) >>> FIXED_POINT) + (c_valid ? c : out).
// Operands presented with their valid strobe are used directly and also
// remembered, so a later compute without the strobe reuses the last value.
//   clk, rst_n                  : clock, synchronous active-low reset
//   a, b, c                     : signed fixed-point operands
//   a_valid, b_valid, c_valid   : operand strobes
//   compute                     : perform one multiply-accumulate
//   out                         : registered result / accumulator
module fma
  import fma_pkg::*;
#(
  parameter int WIDTH       = FMA_WIDTH,
  parameter int FIXED_POINT = FMA_FIXED_POINT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             a_valid,
  input  logic             b_valid,
  input  logic             c_valid,
  input  logic             compute,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0]          a_q, b_q;
  logic [WIDTH-1:0]          a_eff, b_eff, c_eff;
  logic signed [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]          scaled;

  assign a_eff   = a_valid ? a : a_q;
  assign b_eff   = b_valid ? b : b_q;
  // Without a fresh addend the product accumulates onto the current output.
  assign c_eff   = c_valid ? c : out;
  assign product = $signed(a_eff) * $signed(b_eff);
  // Dropping the fractional bits realigns the product to the operand format;
  // the integer overflow simply wraps.
  assign scaled  = WIDTH'(product >>> FIXED_POINT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      out <= '0;
    end else begin
      if (a_valid) a_q <= a;
      if (b_valid) b_q <= b;
      if (compute) out <= scaled + c_eff;
    end
  end

endmodule

// File: rtl/dot_product_sequencer.sv
// Control stage that feeds a paired FMA so its accumulator ends at
// bias + sum(a*b), then captures the FMA output as a one-cycle result pulse.
//   clk_in, rst_in          : clock, synchronous active-low reset
//   start_in/len_in/bias_in : start command, sampled only in IDLE
//   busy_out                : high whenever not IDLE
//   elem_*                  : valid/ready stream of (a, b) element pairs
//   fma_*_out               : operands and strobes for the paired FMA
//   fma_result_in           : registered output of the paired FMA
//   result_out              : captured dot product, held until next capture
//   result_valid_out        : one-cycle pulse marking a new result
module dot_product_sequencer
  import fma_pkg::*;
#(
  parameter int WIDTH   = FMA_WIDTH,
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic [WIDTH-1:0] bias_in,
  output logic             busy_out,
  input  logic [WIDTH-1:0] elem_a_in,
  input  logic [WIDTH-1:0] elem_b_in,
  input  logic             elem_valid_in,
  output logic             elem_ready_out,
  output logic [WIDTH-1:0] fma_a_out,
  output logic [WIDTH-1:0] fma_b_out,
  output logic [WIDTH-1:0] fma_c_out,
  output logic             fma_a_valid_out,
  output logic             fma_b_valid_out,
  output logic             fma_c_valid_out,
  output logic             fma_compute_out,
  input  logic [WIDTH-1:0] fma_result_in,
  output logic [WIDTH-1:0] result_out,
  output logic             result_valid_out
);

  seq_state_t       state_q, state_d;
  logic [LEN_W-1:0] count_q, len_q, len_sat, count_inc;
  logic [WIDTH-1:0] bias_q, result_q;
  logic             fire;

  assign len_sat    = (len_in > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_in;
  assign count_inc  = count_q + LEN_W'(1);
  assign result_out = result_q;

  // NOTE: every output gets a default before the case statement so that no
  // path through this block leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d          = state_q;
    fire             = 1'b0;
    busy_out         = (state_q != IDLE);
    elem_ready_out   = 1'b0;
    result_valid_out = 1'b0;
    fma_a_out        = '0;
    fma_b_out        = '0;
    fma_c_out        = '0;
    fma_a_valid_out  = 1'b0;
    fma_b_valid_out  = 1'b0;
    fma_c_valid_out  = 1'b0;
    fma_compute_out  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_in) state_d = (len_in == '0) ? ZERO : RUN;
      end
      RUN: begin
        // Ready is a function of state alone, so it never waits on valid.
        elem_ready_out  = 1'b1;
        fire            = elem_valid_in;
        fma_a_out       = elem_a_in;
        fma_b_out       = elem_b_in;
        fma_c_out       = bias_q;
        fma_a_valid_out = fire;
        fma_b_valid_out = fire;
        fma_compute_out = fire;
        // Only the first product picks up the bias; the rest accumulate.
        fma_c_valid_out = fire && (count_q == '0);
        if (fire && (count_inc == len_q)) state_d = DRAIN;
      end
      ZERO: begin
        // An empty vector still runs one compute so the FMA output is the bias.
        fma_c_out       = bias_q;
        fma_a_valid_out = 1'b1;
        fma_b_valid_out = 1'b1;
        fma_c_valid_out = 1'b1;
        fma_compute_out = 1'b1;
        state_d         = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        result_valid_out = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      count_q  <= '0;
      len_q    <= '0;
      bias_q   <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_in) begin
            len_q   <= len_sat;
            bias_q  <= bias_in;
            count_q <= '0;
          end
        end
        RUN: begin
          if (fire) count_q <= count_inc;
        end
        DRAIN: result_q <= fma_result_in;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench: dot_product_sequencer paired with fma, driven by
// directed and randomized vectors, checked against an arithmetic model of
// bias + sum((a*b) >>> 10) wrapped to 16 bits.
module tb_dot_product_sequencer;

  localparam int WIDTH   = 16;
  localparam int MAX_LEN = 256;
  localparam int LEN_W   = 9;

  logic             clk;
  logic             rst;
  logic             start_in;
  logic [LEN_W-1:0] len_in;
  logic [WIDTH-1:0] bias_in;
  logic             busy;
  logic [WIDTH-1:0] elem_a, elem_b;
  logic             elem_valid, elem_ready;
  logic [WIDTH-1:0] fma_a, fma_b, fma_c;
  logic             fma_a_valid, fma_b_valid, fma_c_valid, fma_compute;
  logic [WIDTH-1:0] fma_result;
  logic [WIDTH-1:0] result;
  logic             result_valid;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];

  dot_product_sequencer #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .start_in        (start_in),
    .len_in          (len_in),
    .bias_in         (bias_in),
    .busy_out        (busy),
    .elem_a_in       (elem_a),
    .elem_b_in       (elem_b),
    .elem_valid_in   (elem_valid),
    .elem_ready_out  (elem_ready),
    .fma_a_out       (fma_a),
    .fma_b_out       (fma_b),
    .fma_c_out       (fma_c),
    .fma_a_valid_out (fma_a_valid),
    .fma_b_valid_out (fma_b_valid),
    .fma_c_valid_out (fma_c_valid),
    .fma_compute_out (fma_compute),
    .fma_result_in   (fma_result),
    .result_out      (result),
    .result_valid_out(result_valid)
  );

  fma #(.WIDTH(WIDTH), .FIXED_POINT(10)) u_fma (
    .clk    (clk),
    .rst_n  (rst),
    .a      (fma_a),
    .b      (fma_b),
    .c      (fma_c),
    .a_valid(fma_a_valid),
    .b_valid(fma_b_valid),
    .c_valid(fma_c_valid),
    .compute(fma_compute),
    .out    (fma_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: bias plus the fixed-point product of each of the first n pairs.
  function automatic logic [WIDTH-1:0] dot_ref(input logic [WIDTH-1:0] bias, input int n);
    int sum;
    sum = int'($signed(bias));
    for (int i = 0; i < n; i++) begin
      logic signed [WIDTH-1:0] sa, sb;
      int p;
      sa  = qa[i];
      sb  = qb[i];
      p   = sa * sb;
      sum = sum + (p >>> 10);
    end
    return sum[WIDTH-1:0];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int n);
    qa.delete();
    qb.delete();
    for (int i = 0; i < n; i++) begin
      qa.push_back(WIDTH'($urandom));
      qb.push_back(WIDTH'($urandom));
    end
  endtask

  // Runs one dot product over qa/qb. gap >= 0: that many idle cycles before
  // each pair after the first; gap < 0: random valid. glitch_at >= 0 pulses
  // a conflicting start together with that element.
  task automatic run_seq(input logic [WIDTH-1:0] bias, input int len_val,
                         input int gap, input int glitch_at, input string tag);
    int n_eff, fires, cyc, wait_left;
    logic v;
    logic [WIDTH-1:0] exp;
    n_eff     = (len_val > MAX_LEN) ? MAX_LEN : len_val;
    exp       = dot_ref(bias, n_eff);
    fires     = 0;
    cyc       = 0;
    wait_left = 0;
    start_in   = 1'b1;
    len_in     = LEN_W'(len_val);
    bias_in    = bias;
    elem_valid = 1'b0;
    next_cycle();
    start_in = 1'b0;
    while (fires < n_eff && cyc < 4000) begin
      if (gap >= 0) v = (wait_left == 0);
      else          v = ($urandom_range(99) < 60);
      elem_valid = v;
      elem_a     = v ? qa[fires] : WIDTH'($urandom);
      elem_b     = v ? qb[fires] : WIDTH'($urandom);
      if (v && fires == glitch_at) begin
        start_in = 1'b1;
        len_in   = 9'd5;
        bias_in  = 16'h7777;
      end
      #1;
      check({tag, "_ready"}, elem_ready, 1);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_compute"}, fma_compute, v);
      check({tag, "_c_valid"}, fma_c_valid, v && fires == 0);
      if (v) begin
        check({tag, "_fma_a"}, fma_a, qa[fires]);
        fires++;
        wait_left = (gap > 0) ? gap : 0;
      end else if (wait_left > 0) begin
        wait_left--;
      end
      next_cycle();
      start_in = 1'b0;
      cyc++;
    end
    check({tag, "_fires"}, fires, n_eff);
    // Cycle after the last fire: DRAIN, ready already low, no pulse yet.
    elem_valid = 1'b1;
    #1;
    check({tag, "_drain_ready"}, elem_ready, 0);
    check({tag, "_drain_compute"}, fma_compute, 0);
    check({tag, "_drain_pulse"}, result_valid, 0);
    next_cycle();
    elem_valid = 1'b0;
    check({tag, "_pulse"}, result_valid, 1);
    check({tag, "_result"}, result, exp);
    next_cycle();
    check({tag, "_pulse_end"}, result_valid, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    int computes;
    rst        = 1'b0;
    start_in   = 1'b1;
    len_in     = 9'd3;
    bias_in    = 16'h0400;
    elem_valid = 1'b1;
    elem_a     = 16'h0400;
    elem_b     = 16'h0400;

    // 1. Reset held with start and valid asserted: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("rst_busy", busy, 0);
      check("rst_ready", elem_ready, 0);
      check("rst_pulse", result_valid, 0);
      check("rst_result", result, 0);
      check("rst_strobes", {fma_a_valid, fma_b_valid, fma_c_valid, fma_compute}, 0);
      check("rst_fma_c", fma_c, 0);
    end
    start_in   = 1'b0;
    elem_valid = 1'b0;
    rst        = 1'b1;
    next_cycle();

    // 2. bias 1.0, pairs (1,2) (0.5,0.5) (3,1), back-to-back -> 6.25.
    qa = '{16'h0400, 16'h0200, 16'h0C00};
    qb = '{16'h0800, 16'h0200, 16'h0400};
    check("ref_directed", dot_ref(16'h0400, 3), 16'h1900);
    run_seq(16'h0400, 3, 0, -1, "b2b");

    // 3. Same vector with two bubble cycles between pairs.
    run_seq(16'h0400, 3, 2, -1, "bubble");

    // 4. Empty vector: one compute of 0*0 + bias. Counting the start cycle
    //    as the first, the pulse lands in the fourth cycle.
    start_in = 1'b1;
    len_in   = 9'd0;
    bias_in  = 16'h0A00;
    computes = 0;
    next_cycle();
    start_in = 1'b0;
    check("zero_fma_a", fma_a, 0);
    check("zero_fma_b", fma_b, 0);
    check("zero_fma_c", fma_c, 16'h0A00);
    check("zero_strobes", {fma_a_valid, fma_b_valid, fma_c_valid, fma_compute}, 4'hF);
    check("zero_ready", elem_ready, 0);
    if (fma_compute) computes++;
    next_cycle();
    check("zero_drain_pulse", result_valid, 0);
    if (fma_compute) computes++;
    next_cycle();
    if (fma_compute) computes++;
    check("zero_computes", computes, 1);
    check("zero_pulse", result_valid, 1);
    check("zero_result", result, 16'h0A00);
    next_cycle();
    check("zero_pulse_end", result_valid, 0);

    // 5a. A start pulsed mid-run is ignored.
    fill_random(4);
    run_seq(16'h0100, 4, 0, 2, "glitch");

    // 5b. Over-long length saturates to MAX_LEN elements.
    fill_random(MAX_LEN);
    run_seq(WIDTH'($urandom), MAX_LEN + 5, 0, -1, "maxlen");

    // Randomized vectors with random valid gaps.
    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(12, 1);
      fill_random(n);
      run_seq(WIDTH'($urandom), n, -1, -1, "rand");
    end

    // 6. Reset after the second of three fires abandons the operation.
    fill_random(3);
    start_in = 1'b1;
    len_in   = 9'd3;
    bias_in  = 16'h0400;
    next_cycle();
    start_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      elem_valid = 1'b1;
      elem_a     = qa[i];
      elem_b     = qb[i];
      next_cycle();
    end
    elem_valid = 1'b0;
    rst        = 1'b0;
    next_cycle();
    rst = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    for (int i = 0; i < 5; i++) begin
      check("abort_no_pulse", result_valid, 0);
      next_cycle();
    end
    qa = '{16'h0400};
    qb = '{16'h0400};
    run_seq(16'h0000, 1, 0, -1, "after_abort");
    check("after_abort_val", result, 16'h0400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
